// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - HD44780 read-side bus sequencer with optional busy-flag polling
module lcd_bus_reader #(
  parameter int SETUP_CYC = 2,
  parameter int EN_HIGH   = 16,
  parameter int EN_LOW    = 25,
  parameter int POLL_MAX  = 4096
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oTimeout
);

  localparam int PH_MAX = (SETUP_CYC > EN_HIGH) ?
                          ((SETUP_CYC > EN_LOW) ? SETUP_CYC : EN_LOW) :
                          ((EN_HIGH > EN_LOW) ? EN_HIGH : EN_LOW);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_t;

  state_t           state, nextState;
  logic [PH_W-1:0]  phaseCnt;
  logic [CNT_W-1:0] readCnt;
  logic             rsLat;
  logic             pollLat;
  logic             phaseEnd;
  logic             inXfer;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      phaseCnt <= '0;
      readCnt  <= '0;
      rsLat    <= 1'b0;
      pollLat  <= 1'b0;
      oData    <= 8'h00;
    end else begin
      state <= nextState;
      if (phaseEnd || state == IDLE || state == DONE)
        phaseCnt <= '0;
      else
        phaseCnt <= phaseCnt + 1'b1;
      if (state == IDLE && iStart) begin
        rsLat   <= iPoll ? 1'b0 : iRS;
        pollLat <= iPoll;
        readCnt <= '0;
      end
      // Sample on the edge that ends the final EN-high cycle
      if (state == EN_HI && phaseEnd) begin
        oData <= LCD_DATA_IN;
        if (readCnt < CNT_W'(POLL_MAX))
          readCnt <= readCnt + 1'b1;
      end
    end
  end

  always_comb begin
    phaseEnd  = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        if (iStart) nextState = SETUP;
      end
      SETUP: begin
        phaseEnd = (phaseCnt == PH_W'(SETUP_CYC - 1));
        if (phaseEnd) nextState = EN_HI;
      end
      EN_HI: begin
        phaseEnd = (phaseCnt == PH_W'(EN_HIGH - 1));
        if (phaseEnd) nextState = EN_LO;
      end
      EN_LO: begin
        phaseEnd = (phaseCnt == PH_W'(EN_LOW - 1));
        if (phaseEnd) begin
          // oData[7] already holds the busy flag from the read just finished
          if (pollLat && oData[7] && readCnt < CNT_W'(POLL_MAX))
            nextState = SETUP;
          else
            nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    inXfer   = 1'b0;
    LCD_RW   = 1'b0;
    LCD_RS   = 1'b0;
    LCD_EN   = 1'b0;
    oBusy    = 1'b0;
    oDone    = 1'b0;
    oTimeout = 1'b0;
    inXfer   = (state == SETUP) || (state == EN_HI) || (state == EN_LO);
    LCD_RW   = inXfer;
    LCD_RS   = inXfer & rsLat;
    LCD_EN   = (state == EN_HI);
    oBusy    = (state != IDLE);
    oDone    = (state == DONE);
    oTimeout = (state == DONE) & pollLat & oData[7];
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - scoreboard bench for lcd_bus_reader
module tb_lcd_bus_reader;

  logic       iCLK = 1'b0;
  logic       iRST, iStart, iRS, iPoll;
  logic [7:0] LCD_DATA_IN;
  logic       LCD_RW, LCD_RS, LCD_EN, oBusy, oDone, oTimeout;
  logic [7:0] oData;

  always #5 iCLK = ~iCLK;

  lcd_bus_reader #(.SETUP_CYC(2), .EN_HIGH(16), .EN_LOW(25), .POLL_MAX(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN),
    .oBusy(oBusy), .oDone(oDone), .oData(oData), .oTimeout(oTimeout)
  );

  typedef struct {
    logic [7:0] data;
    logic       timeout;
    int         pulses;
    int         latency;
    logic       rs;
  } exp_t;

  exp_t       sbQ[$];
  logic [7:0] respQ[$];
  int         tests = 0;
  int         fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void pushExp(logic [7:0] d, logic to, int p, logic rs);
    exp_t e;
    e.data = d; e.timeout = to; e.pulses = p; e.rs = rs;
    e.latency = 44 + (p - 1) * 43;
    sbQ.push_back(e);
  endfunction

  // LCD model: each new EN pulse presents the next queued byte, last one sticks
  logic enPrevM = 1'b0;
  always @(negedge iCLK) begin
    if (LCD_EN && !enPrevM && respQ.size() > 0) LCD_DATA_IN = respQ.pop_front();
    enPrevM = LCD_EN;
  end

  // Monitor
  logic busyPrev = 1'b0, enPrev = 1'b0;
  int   cyc = 0, pulses = 0, enWidth = 0;
  always @(negedge iCLK) begin
    exp_t e;
    if (oBusy === 1'b1 && !busyPrev) begin
      cyc = 1; pulses = 0;
    end else if (oBusy === 1'b1) cyc++;
    if (LCD_EN === 1'b1 && !enPrev) begin
      pulses++; enWidth = 1;
      check("rw_during_en", LCD_RW, 1);
      if (sbQ.size() > 0) check("rs_during_en", LCD_RS, sbQ[0].rs);
    end else if (LCD_EN === 1'b1) enWidth++;
    if (LCD_EN === 1'b0 && enPrev && oBusy === 1'b1) check("en_width", enWidth, 16);
    if (oDone === 1'b1) begin
      if (sbQ.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sbQ.pop_front();
        check("data", oData, e.data);
        check("timeout", oTimeout, e.timeout);
        check("en_pulses", pulses, e.pulses);
        check("latency", cyc, e.latency);
        check("rw_at_done", LCD_RW, 0);
        check("rs_at_done", LCD_RS, 0);
      end
    end else if (iRST === 1'b0) begin
      check("timeout_idle", oTimeout, 0);
    end
    busyPrev = (oBusy === 1'b1);
    enPrev   = (LCD_EN === 1'b1);
  end

  task automatic startRead(logic rs, logic poll);
    @(posedge iCLK); #1;
    iStart = 1'b1; iRS = rs; iPoll = poll;
    @(posedge iCLK); #1;
    iStart = 1'b0;
  endtask

  task automatic waitIdle(string name);
    int n = 0;
    while (oBusy && n < 1000) begin
      @(posedge iCLK); #1;
      n++;
    end
    check(name, oBusy, 0);
    repeat (2) @(posedge iCLK);
    #1;
  endtask

  initial begin
    int n;
    iRST = 1'b1; iStart = 1'b0; iRS = 1'b0; iPoll = 1'b0; LCD_DATA_IN = 8'h00;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_en", LCD_EN, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_data", oData, 0);
    check("rst_timeout", oTimeout, 0);
    iRST = 1'b0;

    // data read
    respQ.push_back(8'h41); pushExp(8'h41, 1'b0, 1, 1'b1);
    startRead(1'b1, 1'b0); waitIdle("t1_idle");
    // busy-flag read without polling
    respQ.push_back(8'h85); pushExp(8'h85, 1'b0, 1, 1'b0);
    startRead(1'b0, 1'b0); waitIdle("t2_idle");
    // poll: three busy reads then clear; iRS=1 must be ignored
    respQ.push_back(8'h80); respQ.push_back(8'h80); respQ.push_back(8'h80); respQ.push_back(8'h0A);
    pushExp(8'h0A, 1'b0, 4, 1'b0);
    startRead(1'b1, 1'b1); waitIdle("t3_idle");
    // poll timeout at POLL_MAX=4
    respQ.push_back(8'h80); pushExp(8'h80, 1'b1, 4, 1'b0);
    startRead(1'b0, 1'b1); waitIdle("t4_idle");

    // reset on the 10th EN-high cycle
    respQ.push_back(8'h77);
    startRead(1'b1, 1'b0);
    n = 0;
    while (!LCD_EN && n < 100) begin @(posedge iCLK); #1; n++; end
    check("t5_en_seen", LCD_EN, 1);
    repeat (9) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check("t5_en", LCD_EN, 0);
    check("t5_rw", LCD_RW, 0);
    check("t5_rs", LCD_RS, 0);
    check("t5_busy", oBusy, 0);
    check("t5_done", oDone, 0);
    check("t5_data", oData, 0);
    iRST = 1'b0;
    respQ.push_back(8'h5A); pushExp(8'h5A, 1'b0, 1, 1'b1);
    startRead(1'b1, 1'b0); waitIdle("t5b_idle");

    // iStart held high: back-to-back reads with one idle cycle between
    respQ.push_back(8'h33); respQ.push_back(8'h44);
    pushExp(8'h33, 1'b0, 1, 1'b1); pushExp(8'h44, 1'b0, 1, 1'b1);
    @(posedge iCLK); #1;
    iStart = 1'b1; iRS = 1'b1; iPoll = 1'b0;
    n = 0;
    while (!oDone && n < 200) begin @(posedge iCLK); #1; n++; end
    check("t6_done_seen", oDone, 1);
    @(posedge iCLK); #1;
    check("t6_idle_gap", oBusy, 0);
    @(posedge iCLK); #1;
    check("t6_reaccept", oBusy, 1);
    iStart = 1'b0;
    repeat (3) begin
      repeat (5) @(posedge iCLK);
      #1; iStart = 1'b1;
      @(posedge iCLK); #1; iStart = 1'b0;
    end
    waitIdle("t6_idle");
    repeat (10) @(posedge iCLK);
    #1;
    check("t6_no_queue", oBusy, 0);
    check("sb_empty", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
